// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory slave with fixed response latency and illegal-address flagging.
// Ports:
//   clk_i            clock, all state changes on the rising edge
//   rst_i            asynchronous active-low reset
//   req_i            request valid, accepted when ready_o = 1
//   we_i             1 = write, 0 = read
//   addr_i           byte address, word index addr_i[31:2]
//   wdata_i          write data
//   ready_o          high only while idle
//   rvalid_o         one-cycle read-data-valid pulse
//   rdata_o          read data, zero unless rvalid_o
//   wack_o           one-cycle write-complete pulse
//   err_o            flags the response of a misaligned or out-of-range request
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        wack_o,
  output logic        err_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic        rvalid_q, wack_q, err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [DEPTH];
  logic        accept, cur_we, bad_q, commit;
  logic [31:0] cur_addr, cur_wdata;
  function automatic logic illegal(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction
  assign accept    = req_i && (state_q == IDLE);
  assign ready_o   = (state_q == IDLE);
  // With zero latency RESP is entered on the accepting edge itself, before the
  // request registers hold the request, so the commit must look at the inputs.
  assign cur_we    = (state_q == IDLE) ? we_i    : we_q;
  assign cur_addr  = (state_q == IDLE) ? addr_i  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? wdata_i : wdata_q;
  assign commit    = (state_d == RESP) && (state_q != RESP) && cur_we && !illegal(cur_addr);
  assign bad_q     = illegal(addr_q);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = (LATENCY == 0) ? RESP : WAIT;
      cnt_d   = 4'(LATENCY);
    end else if (state_q == WAIT) begin
      state_d = (cnt_q == 4'd1) ? RESP : WAIT;
      cnt_d   = cnt_q - 4'd1;
    end else if (state_q != IDLE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[cur_addr[AW+1:2]] <= cur_wdata;
    end
  end
  // Response flags are registered off the RESP cycle, so the pulse lands in
  // the cycle after the edge that leaves RESP. The array is not written while
  // in RESP, so reading it on the leaving edge yields the word as it stood at
  // the RESP-entry edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= (state_q == RESP) && !we_q;
      wack_q   <= (state_q == RESP) && we_q;
      err_q    <= (state_q == RESP) && bad_q;
      rdata_q  <= ((state_q == RESP) && !we_q && !bad_q) ? mem_q[addr_q[AW+1:2]] : '0;
    end
  end
  assign rvalid_o = rvalid_q;
  assign wack_o   = wack_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed table-driven bench for data_mem_responder at LATENCY 2 and 0.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, req0 = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, rvalid, wack, err;
  logic [31:0] rdata;
  logic        ready0, rvalid0, wack0, err0;
  logic [31:0] rdata0;
  int checks = 0;
  int failures = 0;
  data_mem_responder #(.DEPTH(128), .LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready), .rvalid_o(rvalid), .rdata_o(rdata), .wack_o(wack), .err_o(err)
  );
  data_mem_responder #(.DEPTH(128), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req0), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready0), .rvalid_o(rvalid0), .rdata_o(rdata0), .wack_o(wack0), .err_o(err0)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        erv;
    logic        ewk;
    logic        eer;
    logic [31:0] erd;
  } vec_t;
  vec_t vecs[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Called at a falling edge with the selected DUT idle; returns at the falling
  // edge where the response pulse is visible.
  task automatic txn(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input string tag, input logic erv, input logic ewk, input logic eer,
                     input logic [31:0] erd);
    int k;
    int lows;
    int elat;
    elat = sel ? 1 : 3;
    lows = 0;
    we = w;
    addr = a;
    wdata = d;
    if (sel) req0 = 1'b1; else req = 1'b1;
    @(posedge clk);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      req = 1'b0;
      req0 = 1'b0;
      we = ~w;
      addr = $urandom;
      wdata = $urandom;
      if (sel ? (rvalid0 | wack0) : (rvalid | wack)) break;
      if (!(sel ? ready0 : ready)) lows++;
    end
    chk($sformatf("%s_latency", tag), k, elat);
    chk($sformatf("%s_ready_low", tag), lows, elat);
    chk($sformatf("%s_rvalid", tag), sel ? rvalid0 : rvalid, erv);
    chk($sformatf("%s_wack", tag), sel ? wack0 : wack, ewk);
    chk($sformatf("%s_err", tag), sel ? err0 : err, eer);
    chk($sformatf("%s_rdata", tag), sel ? rdata0 : rdata, erd);
  endtask
  logic [31:0] bp_addr [17];
  logic [31:0] bp_data [17];
  initial begin
    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h13,  32'h11111111, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h200, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 32'h12,  32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h1FC, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h1FC, 32'h0,        1'b1, 1'b0, 1'b0, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 32'h200, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h4,   32'h01234567, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h4,   32'h0,        1'b1, 1'b0, 1'b0, 32'h01234567};
    for (int j = 0; j < 17; j++) begin
      bp_addr[j] = 32'h8;
      bp_data[j] = 32'h0;
    end
    bp_addr[0] = 32'h10;  bp_data[0] = 32'hDEADBEEF;
    bp_addr[4] = 32'h4;   bp_data[4] = 32'h01234567;
    bp_addr[8] = 32'h1FC; bp_data[8] = 32'hA5A5A5A5;
    bp_addr[12] = 32'h10; bp_data[12] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wack", wack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ready0", ready0, 1);
    rst_n = 1'b1;
    txn(1, 1'b0, 32'h0, 32'h0, "l0_rd0", 1, 0, 0, 32'h0);
    txn(1, 1'b1, 32'h8, 32'h55AA55AA, "l0_wr8", 0, 1, 0, 32'h0);
    txn(1, 1'b0, 32'h8, 32'h0, "l0_rd8", 1, 0, 0, 32'h55AA55AA);
    txn(1, 1'b0, 32'h200, 32'h0, "l0_rdbad", 1, 0, 1, 32'h0);
    for (int i = 0; i < 12; i++)
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i),
          vecs[i].erv, vecs[i].ewk, vecs[i].eer, vecs[i].erd);
    we = 1'b0;
    for (int j = 0; j < 17; j++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ready", j), ready, (j % 4 == 0) ? 1 : 0);
      chk($sformatf("bp%0d_rvalid", j), rvalid, (j >= 4 && j % 4 == 0) ? 1 : 0);
      chk($sformatf("bp%0d_rdata", j), rdata, (j >= 4 && j % 4 == 0) ? bp_data[j-4] : 32'h0);
      req = (j < 16);
      addr = bp_addr[j];
    end
    @(negedge clk);
    we = 1'b1;
    addr = 32'h20;
    wdata = 32'h12345678;
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("mrst%0d_wack", j), wack, 0);
      chk($sformatf("mrst%0d_ready", j), ready, 1);
    end
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h20, 32'h0, "mrst_rd20", 1, 0, 0, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, "mrst_rd10", 1, 0, 0, 32'h0);
    txn(0, 1'b0, 32'h1FC, 32'h0, "mrst_rd1fc", 1, 0, 0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 128, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between acceptance and response; legal range 0..15.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_i, input, 1 bit: initiator request valid.
REQ-006 SHALL have port we_i, input, 1 bit: 1 = write, 0 = read; sampled with req_i.
REQ-007 SHALL have port addr_i, input, 32 bits: byte address; word index is addr_i[31:2].
REQ-008 SHALL have port wdata_i, input, 32 bits: write data; sampled with req_i.
REQ-009 SHALL have port ready_o, output, 1 bit: responder can accept a request this cycle.
REQ-010 SHALL have port rvalid_o, output, 1 bit: one-cycle pulse, read data valid.
REQ-011 SHALL have port rdata_o, output, 32 bits: read data; meaningful only while rvalid_o = 1.
REQ-012 SHALL have port wack_o, output, 1 bit: one-cycle pulse, write completed.
REQ-013 SHALL have port err_o, output, 1 bit: asserted with the rvalid_o or wack_o pulse when the request was illegal.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-015 SHALL drive ready_o = 1 only in IDLE.
REQ-016 SHALL accept a request at a rising edge where req_i = 1 and ready_o = 1, latching we_i, addr_i and wdata_i into internal registers.
REQ-017 SHALL ignore req_i and all request inputs while not in IDLE; changes to the inputs after acceptance SHALL NOT affect the transaction.
REQ-018 SHALL, on acceptance, go to WAIT and load the wait counter with LATENCY; with LATENCY = 0 it SHALL go directly to RESP.
REQ-019 SHALL decrement the counter in WAIT each cycle and enter RESP on the edge where the counter equals 1.
REQ-020 SHALL place the response in the cycle after edge E0+LATENCY+1, where E0 is the accepting edge.
REQ-021 SHALL hold RESP for exactly one cycle, then return to IDLE; maximum throughput is one request per LATENCY+2 cycles.
REQ-022 SHALL, in RESP for a read, assert rvalid_o = 1 and drive rdata_o = mem[addr[31:2]] as read at the RESP-entry edge.
REQ-023 SHALL, in RESP for a write, assert wack_o = 1; the array update SHALL occur on the RESP-entry edge and be visible to any later read.
REQ-024 SHALL treat a request as illegal when addr[1:0] != 0 or addr[31:2] >= DEPTH.
REQ-025 SHALL, for an illegal request, still complete with normal timing, assert err_o = 1 in RESP, leave memory unmodified, and drive rdata_o = 0.
REQ-026 SHALL hold rvalid_o, wack_o and err_o at 0 outside RESP, and hold rdata_o at 0 whenever rvalid_o = 0.
REQ-027 SHALL never assert rvalid_o and wack_o in the same cycle.

Reset
REQ-028 SHALL, while rst_i = 0, force: state IDLE, counter 0, ready_o = 1, rvalid_o = 0, wack_o = 0, err_o = 0, rdata_o = 0, and latched request registers to 0.
REQ-029 SHALL clear all DEPTH memory words to 0 on reset.
REQ-030 SHALL, when reset is asserted mid-transaction (WAIT or RESP), abort the transaction with no response pulse and no memory write; a write already committed at the RESP-entry edge is still cleared by REQ-029.
REQ-031 SHALL accept a request at the first rising edge after rst_i deasserts.

Verification
REQ-032 Write then read, LATENCY = 2: write addr 0x10, data 0xDEADBEEF accepted at edge 0 -> wack_o high for the cycle after edge 3; read addr 0x10 -> rvalid_o = 1, rdata_o = 0xDEADBEEF, err_o = 0.
REQ-033 Illegal requests: write addr 0x13, then read addr 0x200 (DEPTH = 128) -> both complete with err_o = 1; read of addr 0x10 is unchanged; rdata_o = 0 on the error read.
REQ-034 Back-pressure: hold req_i = 1 continuously with changing addresses -> ready_o low for LATENCY+1 cycles after each acceptance; exactly one request accepted per LATENCY+2 cycles; only addresses sampled at accepting edges are used.
REQ-035 LATENCY = 0: read addr 0x0 after reset -> response in the cycle after edge E0+1, rdata_o = 0x00000000.
REQ-036 Mid-operation reset: accept write addr 0x20, data 0x12345678, then pull rst_i low during WAIT -> no wack_o; after release, read addr 0x20 returns 0x00000000.
REQ-037 Boundary: write and read back the last word, addr 4*(DEPTH-1) = 0x1FC, data 0xA5A5A5A5 -> read returns 0xA5A5A5A5 with err_o = 0.
